dcm_supervisor: RTL and testbench

Reset and lock sequencer for the board clock DCM. It drives the DCM reset, waits for lock, and then holds a settle interval before releasing the downstream system/DDR reset. After release it watches for lock loss or a stopped CLKFX and re-runs the sequence, with bounded retries and a sticky fault. It runs in the 33 MHz input clock domain, alongside the clocking wrapper, and gates the MIG and core reset.

---
 rtl/dcm_supervisor.sv | 148 ++++++++++++++
 tb/tb_dcm_supervisor.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_supervisor.sv
// DCM reset/lock sequencer: pulses DCM reset, waits for lock, holds a settle
// window, then releases the downstream reset; recovers from lock loss with bounded retries.
module dcm_supervisor #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dcm_locked,
    input  logic       dcm_clkfx_stopped,
    input  logic       force_relock,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);
    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_count_q, retry_count_d;
    logic [7:0]  loss_count_q, loss_count_d;
    logic [1:0]  lock_sync_q, lock_sync_d;
    logic [1:0]  stop_sync_q, stop_sync_d;
    logic        dcm_rst_q, dcm_rst_d;
    logic        sys_rst_q, sys_rst_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        locked_s, stop_s, fail;

    assign locked_s = lock_sync_q[1];
    assign stop_s   = stop_sync_q[1];

    always_comb begin
        lock_sync_d   = {lock_sync_q[0], dcm_locked};
        stop_sync_d   = {stop_sync_q[0], dcm_clkfx_stopped};
        state_d       = state_q;
        cnt_d         = cnt_q + 16'd1;
        retry_count_d = retry_count_q;
        loss_count_d  = loss_count_q;
        fail          = 1'b0;

        case (state_q)
            S_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                // Lock takes precedence over a timeout landing on the same cycle.
                if (locked_s) state_d = S_SETTLE;
                else if (cnt_q == TIMEOUT_LAST) fail = 1'b1;
            end
            S_SETTLE: begin
                if (!locked_s || stop_s) begin
                    fail = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d       = S_RUN;
                    retry_count_d = 4'd0;
                end
            end
            S_RUN: begin
                if (!locked_s || stop_s) begin
                    state_d = S_RST;
                    if (loss_count_q != 8'hFF) loss_count_d = loss_count_q + 8'd1;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RST;
            end
        endcase

        if (fail) begin
            if (retry_count_q == RETRY_LIMIT) begin
                state_d = S_FAULT;
            end else begin
                retry_count_d = retry_count_q + 4'd1;
                state_d       = S_RST;
            end
        end

        // A relock request overrides everything decided above, including loss counting.
        if (force_relock) begin
            state_d       = S_RST;
            retry_count_d = 4'd0;
            loss_count_d  = loss_count_q;
        end

        if (force_relock || (state_d != state_q) || (state_q == S_RUN) || (state_q == S_FAULT)) begin
            cnt_d = 16'd0;
        end

        dcm_rst_d = (state_d == S_RST) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RST;
            cnt_q         <= 16'd0;
            retry_count_q <= 4'd0;
            loss_count_q  <= 8'd0;
            lock_sync_q   <= 2'b00;
            stop_sync_q   <= 2'b00;
            dcm_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_count_q <= retry_count_d;
            loss_count_q  <= loss_count_d;
            lock_sync_q   <= lock_sync_d;
            stop_sync_q   <= stop_sync_d;
            dcm_rst_q     <= dcm_rst_d;
            sys_rst_q     <= sys_rst_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    assign dcm_rst     = dcm_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_count_q;
    assign loss_count  = loss_count_q;

endmodule

// File: tb/tb_dcm_supervisor.sv
// Self-checking bench for dcm_supervisor: constant vector table, hand-written
// corner sequences and a randomized run against a phase/age reference model.
module tb_dcm_supervisor;
    localparam int RST_CYCLES    = 8;
    localparam int LOCK_TIMEOUT  = 40;
    localparam int SETTLE_CYCLES = 24;
    localparam int MAX_RETRY     = 7;
    localparam int NUM_VEC       = 17;

    localparam int PH_RST = 0, PH_WAIT = 1, PH_SETTLE = 2, PH_RUN = 3, PH_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dcm_locked = 1'b0;
    logic       dcm_clkfx_stopped = 1'b0;
    logic       force_relock = 1'b0;
    logic       dcm_rst, sys_rst, ready, fault;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int checks = 0;
    int errors = 0;

    int m_phase, m_age, m_retries, m_losses;
    bit lk_pipe[$];
    bit st_pipe[$];

    typedef struct {
        bit lk;
        bit st;
        bit fr;
        int cyc;
        bit e_dcm;
        bit e_sys;
        bit e_rdy;
        bit e_flt;
        int e_retry;
        int e_loss;
    } vec_t;

    vec_t tbl[NUM_VEC];

    dcm_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dcm_locked       (dcm_locked),
        .dcm_clkfx_stopped(dcm_clkfx_stopped),
        .force_relock     (force_relock),
        .dcm_rst          (dcm_rst),
        .sys_rst          (sys_rst),
        .ready            (ready),
        .fault            (fault),
        .retry_count      (retry_count),
        .loss_count       (loss_count)
    );

    always #5 clk = ~clk;

    // Reference model: a phase plus the number of cycles spent in it; status inputs
    // reach the decision logic through a two-deep queue.
    function automatic void model_reset();
        m_phase = PH_RST;
        m_age = 0;
        m_retries = 0;
        m_losses = 0;
        lk_pipe.delete();
        st_pipe.delete();
        lk_pipe.push_back(1'b0);
        lk_pipe.push_back(1'b0);
        st_pipe.push_back(1'b0);
        st_pipe.push_back(1'b0);
    endfunction

    function automatic void model_enter(input int ph);
        m_phase = ph;
        m_age = 0;
    endfunction

    function automatic void model_fail();
        if (m_retries == MAX_RETRY) begin
            model_enter(PH_FAULT);
        end else begin
            m_retries = m_retries + 1;
            model_enter(PH_RST);
        end
    endfunction

    function automatic void model_step(input bit lk, input bit st, input bit fr);
        bit ls, ss;
        ls = lk_pipe.pop_front();
        ss = st_pipe.pop_front();
        lk_pipe.push_back(lk);
        st_pipe.push_back(st);
        if (fr) begin
            m_retries = 0;
            model_enter(PH_RST);
            return;
        end
        case (m_phase)
            PH_RST:    if (m_age + 1 == RST_CYCLES) model_enter(PH_WAIT); else m_age = m_age + 1;
            PH_WAIT:   if (ls) model_enter(PH_SETTLE);
                       else if (m_age + 1 == LOCK_TIMEOUT) model_fail();
                       else m_age = m_age + 1;
            PH_SETTLE: if (!ls || ss) model_fail();
                       else if (m_age + 1 == SETTLE_CYCLES) begin
                           m_retries = 0;
                           model_enter(PH_RUN);
                       end else m_age = m_age + 1;
            PH_RUN:    if (!ls || ss) begin
                           m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                           model_enter(PH_RST);
                       end
            default:   m_phase = PH_FAULT;
        endcase
    endfunction

    function automatic logic [15:0] model_vec();
        bit e_dcm, e_sys, e_rdy, e_flt;
        e_dcm = (m_phase == PH_RST) || (m_phase == PH_FAULT);
        e_sys = (m_phase != PH_RUN);
        e_rdy = (m_phase == PH_RUN);
        e_flt = (m_phase == PH_FAULT);
        return {e_dcm, e_sys, e_rdy, e_flt, 4'(m_retries), 8'(m_losses)};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {dcm_rst, sys_rst, ready, fault, retry_count, loss_count};
    endfunction

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [15:0] got, exp;
        got = dut_vec();
        exp = model_vec();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got {dcm,sys,rdy,flt,retry,loss}=%b/%0d/%0d expected %b/%0d/%0d (t=%0t)",
                     name, got[15:12], got[11:8], got[7:0], exp[15:12], exp[11:8], exp[7:0], $time);
        end
    endtask

    task automatic applyStimulus(input bit lk, input bit st, input bit fr);
        dcm_locked = lk;
        dcm_clkfx_stopped = st;
        force_relock = fr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(dcm_locked, dcm_clkfx_stopped, force_relock);
        @(negedge clk);
        checkOutput("model");
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return ready == 1'b1;
            1:       return sys_rst == 1'b1;
            2:       return dcm_rst == 1'b1;
            default: return dcm_rst == 1'b0;
        endcase
    endfunction

    task automatic tickUntil(input int sel, input int limit, output int n);
        n = 0;
        while (!cond(sel) && n < limit) begin
            tick();
            n++;
        end
        if (!cond(sel)) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_cond_%0d: condition not reached within %0d cycles", sel, limit);
            n = -1;
        end
    endtask

    task automatic doReset(input bit lk);
        rst_n = 1'b0;
        applyStimulus(lk, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        model_reset();
        checkOutput("reset_state");
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit lk_cur;

        tbl[0]  = '{1, 0, 0,  7, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,  1, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0,  1, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 23, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0,  1, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0,  1, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 0, 0,  1, 0, 0, 1, 0, 0, 0};
        tbl[7]  = '{1, 0, 0,  1, 1, 1, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 0,  7, 1, 1, 0, 0, 0, 1};
        tbl[9]  = '{1, 0, 0,  1, 0, 1, 0, 0, 0, 1};
        tbl[10] = '{1, 0, 0, 25, 0, 0, 1, 0, 0, 1};
        tbl[11] = '{1, 1, 0,  2, 0, 0, 1, 0, 0, 1};
        tbl[12] = '{1, 0, 0,  1, 1, 1, 0, 0, 0, 2};
        tbl[13] = '{1, 0, 1,  1, 1, 1, 0, 0, 0, 2};
        tbl[14] = '{1, 0, 0,  7, 1, 1, 0, 0, 0, 2};
        tbl[15] = '{1, 0, 0,  1, 0, 1, 0, 0, 0, 2};
        tbl[16] = '{1, 0, 0,  1, 0, 1, 0, 0, 0, 2};

        // Nominal bring-up, one-cycle lock drop, CLKFX stop and relock from the table.
        doReset(1'b1);
        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(tbl[i].lk, tbl[i].st, tbl[i].fr);
            repeat (tbl[i].cyc) tick();
            checkValue($sformatf("table_row_%0d", i), int'(dut_vec()),
                       int'({tbl[i].e_dcm, tbl[i].e_sys, tbl[i].e_rdy, tbl[i].e_flt,
                             4'(tbl[i].e_retry), 8'(tbl[i].e_loss)}));
        end
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Release latency with lock present throughout.
        doReset(1'b1);
        tickUntil(0, 200, n);
        checkValue("release_latency", n, RST_CYCLES + 1 + SETTLE_CYCLES);

        // Timeouts escalate retry_count and then the sticky fault.
        doReset(1'b0);
        for (int k = 1; k <= MAX_RETRY; k++) begin
            repeat (RST_CYCLES + LOCK_TIMEOUT) tick();
            checkValue($sformatf("retry_after_timeout_%0d", k), int'(retry_count), k);
            checkValue("dcm_rst_on_retry", int'(dcm_rst), 1);
        end
        repeat (RST_CYCLES + LOCK_TIMEOUT) tick();
        checkValue("fault_set", int'(fault), 1);
        checkValue("fault_dcm_rst", int'(dcm_rst), 1);
        checkValue("fault_retry", int'(retry_count), MAX_RETRY);
        repeat (10) tick();
        checkValue("fault_sticky", int'(fault), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("relock_clears_fault", int'(fault), 0);
        checkValue("relock_clears_retry", int'(retry_count), 0);
        repeat (RST_CYCLES - 1) tick();
        checkValue("relock_rst_held", int'(dcm_rst), 1);
        tick();
        checkValue("relock_rst_released", int'(dcm_rst), 0);

        // Lock glitch in the middle of the settle window.
        doReset(1'b1);
        repeat (RST_CYCLES + 1 + 12) tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickUntil(2, 10, n);
        checkValue("glitch_retry", int'(retry_count), 1);
        tickUntil(3, 50, n);
        checkValue("glitch_dcm_pulse", n, RST_CYCLES);
        tickUntil(0, 100, n);
        checkValue("glitch_settle_restart", n, SETTLE_CYCLES + 1);
        checkValue("glitch_retry_cleared", int'(retry_count), 0);

        // Repeated lock losses in RUN saturate loss_count.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b1, 1'b0, 1'b0);
            tickUntil(1, 10, n);
            checkValue("loss_latency", n + 1, 3);
            tickUntil(0, 200, n);
        end
        checkValue("loss_saturated", int'(loss_count), 255);
        checkValue("loss_ready_again", int'(ready), 1);

        // Relock on the same cycle as the timeout wins and does not count a failure.
        doReset(1'b0);
        repeat (RST_CYCLES + LOCK_TIMEOUT - 1) tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("prio_retry", int'(retry_count), 0);
        checkValue("prio_dcm_rst", int'(dcm_rst), 1);
        repeat (RST_CYCLES - 1) tick();
        checkValue("prio_rst_restarted", int'(dcm_rst), 1);

        // Synchronized lock arriving exactly at the timeout cycle enters settle.
        doReset(1'b0);
        repeat (RST_CYCLES + LOCK_TIMEOUT - 3) tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        checkValue("coincide_retry", int'(retry_count), 0);
        checkValue("coincide_dcm_rst", int'(dcm_rst), 0);
        tickUntil(0, 100, n);
        checkValue("coincide_settle_len", n, SETTLE_CYCLES);

        // One cycle later the timeout fires first.
        doReset(1'b0);
        repeat (RST_CYCLES + LOCK_TIMEOUT - 2) tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        checkValue("late_lock_retry", int'(retry_count), 1);
        checkValue("late_lock_dcm_rst", int'(dcm_rst), 1);

        // Asynchronous reset in the middle of settle.
        tickUntil(3, 50, n);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async_dcm_rst", int'(dcm_rst), 1);
        checkValue("async_sys_rst", int'(sys_rst), 1);
        checkValue("async_ready", int'(ready), 0);
        checkValue("async_retry", int'(retry_count), 0);
        checkValue("async_loss", int'(loss_count), 0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        tickUntil(0, 200, n);
        checkValue("async_full_rerun", n, RST_CYCLES + 1 + SETTLE_CYCLES);

        // Randomized traffic compared cycle by cycle with the model.
        doReset(1'b1);
        lk_cur = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) lk_cur = ~lk_cur;
            applyStimulus(lk_cur, ($urandom_range(0, 99) == 0), ($urandom_range(0, 299) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
